// File: rtl/gravsim_regfile.sv
// Register file shared by a host bus and a six-port gravity-simulation FSM.
// Also holds the run/done handshake controller and the acceleration-clear sequencer.
module gravsim_regfile #(
    parameter int DEPTH       = 114,
    parameter int MAX_PLANETS = 10
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic        AVL_CS,
    input  logic        AVL_READ,
    input  logic        AVL_WRITE,
    input  logic [6:0]  AVL_ADDR,
    input  logic [31:0] AVL_WRITEDATA,
    output logic [31:0] AVL_READDATA,
    input  logic [1:0]  FSM_re,
    input  logic [1:0]  FSM_we,
    input  logic [31:0] ADDR1,
    input  logic [31:0] ADDR2,
    input  logic [31:0] ADDR3,
    input  logic [31:0] ADDR4,
    input  logic [31:0] ADDR5,
    input  logic [31:0] ADDR6,
    input  logic [31:0] DATA1,
    input  logic [31:0] DATA2,
    input  logic [31:0] DATA3,
    input  logic [31:0] DATA4,
    input  logic [31:0] DATA5,
    input  logic [31:0] DATA6,
    output logic [31:0] DATA1in,
    output logic [31:0] DATA2in,
    output logic [31:0] DATA3in,
    output logic [31:0] DATA4in,
    output logic [31:0] DATA5in,
    output logic [31:0] DATA6in,
    input  logic        FSM_DONE,
    input  logic        clear_accs,
    output logic        FSM_START,
    output logic [31:0] G,
    output logic [3:0]  PLANET_NUM
);

    localparam int              AW        = 7;
    localparam int              NPORTS    = 6;
    localparam logic [31:0]     DEPTH_W   = 32'(DEPTH);
    localparam logic [AW-1:0]   W_G       = 7'd0;
    localparam logic [AW-1:0]   W_NUM     = 7'd1;
    localparam logic [AW-1:0]   W_START   = 7'd2;
    localparam logic [AW-1:0]   W_DONE    = 7'd3;
    localparam logic [AW-1:0]   ACC_FIRST = 7'd84;
    localparam logic [AW-1:0]   ACC_LAST  = 7'd113;
    localparam logic [3:0]      MAX_P     = 4'(MAX_PLANETS);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } ctl_state_t;

    logic [31:0]       mem        [DEPTH];
    logic [31:0]       port_addr  [NPORTS];
    logic [31:0]       port_wdata [NPORTS];
    logic [31:0]       port_rdata [NPORTS];
    logic [AW-1:0]     port_idx   [NPORTS];
    logic [NPORTS-1:0] port_ok;
    logic [NPORTS-1:0] port_re;
    logic [NPORTS-1:0] port_we;

    logic              host_ok;
    logic              host_wr;
    logic              host_rd;
    logic              start_wr;
    logic              start_go;

    ctl_state_t        state;
    ctl_state_t        state_nxt;
    logic              done_q;
    logic              done_rise;
    logic              ctl_arm;
    logic              ctl_finish;

    logic [AW-1:0]     clr_cnt;
    logic              clr_busy;

    // ------------------------------------------------------------------
    // Port bundling and address decode
    // ------------------------------------------------------------------
    assign port_addr[0]  = ADDR1;
    assign port_addr[1]  = ADDR2;
    assign port_addr[2]  = ADDR3;
    assign port_addr[3]  = ADDR4;
    assign port_addr[4]  = ADDR5;
    assign port_addr[5]  = ADDR6;
    assign port_wdata[0] = DATA1;
    assign port_wdata[1] = DATA2;
    assign port_wdata[2] = DATA3;
    assign port_wdata[3] = DATA4;
    assign port_wdata[4] = DATA5;
    assign port_wdata[5] = DATA6;

    // Bank bit 0 drives ports 1-3, bank bit 1 drives ports 4-6.
    assign port_re = {{3{FSM_re[1]}}, {3{FSM_re[0]}}};
    assign port_we = {{3{FSM_we[1]}}, {3{FSM_we[0]}}};

    // The full 32-bit address is compared so that set upper bits mark it out of range.
    always_comb begin
        for (int i = 0; i < NPORTS; i++) begin
            port_ok[i]  = port_addr[i] < DEPTH_W;
            port_idx[i] = port_addr[i][AW-1:0];
        end
    end

    assign host_ok  = {25'd0, AVL_ADDR} < DEPTH_W;
    assign host_wr  = AVL_CS & AVL_WRITE & host_ok;
    assign host_rd  = AVL_CS & AVL_READ;
    assign start_wr = AVL_CS & AVL_WRITE & (AVL_ADDR == W_START);
    assign start_go = start_wr & AVL_WRITEDATA[0];

    // ------------------------------------------------------------------
    // Run/done control FSM
    // ------------------------------------------------------------------
    // NOTE: every flop uses <= so all registers update from the same pre-edge values.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state  <= ST_IDLE;
            done_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            done_q <= FSM_DONE;
        end
    end

    assign done_rise = FSM_DONE & ~done_q;

    // NOTE: default assignment first so no path through the case leaves state_nxt unassigned (no latch).
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start_go)  state_nxt = ST_RUN;
            ST_RUN:  if (done_rise) state_nxt = ST_DONE;
            ST_DONE: begin
                if (start_go)      state_nxt = ST_RUN;
                else if (start_wr) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        ctl_arm    = start_go & (state != ST_RUN);
        ctl_finish = done_rise & (state == ST_RUN);
    end

    // ------------------------------------------------------------------
    // Acceleration-clear sequencer: zero = idle, otherwise the word to clear
    // ------------------------------------------------------------------
    assign clr_busy = clr_cnt != '0;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            clr_cnt <= '0;
        end else if (clear_accs) begin
            clr_cnt <= ACC_FIRST;
        end else if (clr_busy) begin
            clr_cnt <= (clr_cnt == ACC_LAST) ? '0 : clr_cnt + AW'(1);
        end
    end

    // ------------------------------------------------------------------
    // Storage: later assignments win, giving host < FSM ports 1..6 < control < clear
    // ------------------------------------------------------------------
    // NOTE: the array is built from resettable flops rather than a RAM macro, because every word must clear asynchronously.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (host_wr) begin
                mem[AVL_ADDR] <= AVL_WRITEDATA;
            end
            for (int i = 0; i < NPORTS; i++) begin
                if (port_we[i] && port_ok[i]) begin
                    mem[port_idx[i]] <= port_wdata[i];
                end
            end
            if (ctl_arm) begin
                mem[W_DONE] <= '0;
            end
            if (ctl_finish) begin
                mem[W_START] <= '0;
                mem[W_DONE]  <= 32'd1;
            end
            if (clr_busy) begin
                mem[clr_cnt] <= '0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Registered read ports (old data on a same-cycle write)
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int i = 0; i < NPORTS; i++) begin
                port_rdata[i] <= '0;
            end
            AVL_READDATA <= '0;
        end else begin
            for (int i = 0; i < NPORTS; i++) begin
                if (port_re[i]) begin
                    port_rdata[i] <= port_ok[i] ? mem[port_idx[i]] : '0;
                end
            end
            if (host_rd) begin
                AVL_READDATA <= host_ok ? mem[AVL_ADDR] : '0;
            end
        end
    end

    assign DATA1in = port_rdata[0];
    assign DATA2in = port_rdata[1];
    assign DATA3in = port_rdata[2];
    assign DATA4in = port_rdata[3];
    assign DATA5in = port_rdata[4];
    assign DATA6in = port_rdata[5];

    // ------------------------------------------------------------------
    // Decoded configuration outputs
    // ------------------------------------------------------------------
    assign G          = mem[W_G];
    assign FSM_START  = mem[W_START][0];
    assign PLANET_NUM = (mem[W_NUM][3:0] > MAX_P) ? MAX_P : mem[W_NUM][3:0];

endmodule

// File: tb/tb_gravsim_regfile.sv
// Self-checking bench for gravsim_regfile: host table vectors, directed
// multi-cycle sequences, then random traffic against a behavioural model.
module tb_gravsim_regfile;

    localparam int DEPTH   = 114;
    localparam int PH_IDLE = 0;
    localparam int PH_RUN  = 1;
    localparam int PH_DONE = 2;

    logic        CLK;
    logic        RESET_N;
    logic        cs, rd, wr;
    logic [6:0]  a_addr;
    logic [31:0] a_wdata;
    logic [31:0] rdata;
    logic [1:0]  re, we;
    logic [31:0] f_addr [6];
    logic [31:0] f_data [6];
    logic [31:0] din    [6];
    logic        fdone, clr;
    logic        fstart;
    logic [31:0] g;
    logic [3:0]  pnum;

    int checks = 0;
    int errors = 0;

    // behavioural model state
    logic [31:0] m_mem [DEPTH];
    logic [31:0] m_nxt [DEPTH];
    logic [31:0] m_rd  [6];
    logic [31:0] m_avl;
    int          m_phase;
    logic        m_done_prev;
    int          clr_q [$];

    gravsim_regfile dut (
        .CLK(CLK), .RESET_N(RESET_N),
        .AVL_CS(cs), .AVL_READ(rd), .AVL_WRITE(wr),
        .AVL_ADDR(a_addr), .AVL_WRITEDATA(a_wdata), .AVL_READDATA(rdata),
        .FSM_re(re), .FSM_we(we),
        .ADDR1(f_addr[0]), .ADDR2(f_addr[1]), .ADDR3(f_addr[2]),
        .ADDR4(f_addr[3]), .ADDR5(f_addr[4]), .ADDR6(f_addr[5]),
        .DATA1(f_data[0]), .DATA2(f_data[1]), .DATA3(f_data[2]),
        .DATA4(f_data[3]), .DATA5(f_data[4]), .DATA6(f_data[5]),
        .DATA1in(din[0]), .DATA2in(din[1]), .DATA3in(din[2]),
        .DATA4in(din[3]), .DATA5in(din[4]), .DATA6in(din[5]),
        .FSM_DONE(fdone), .clear_accs(clr),
        .FSM_START(fstart), .G(g), .PLANET_NUM(pnum)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #1000000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic logic in_range(input logic [31:0] a);
        return a < 32'(DEPTH);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
        for (int i = 0; i < 6; i++) m_rd[i] = '0;
        m_avl       = '0;
        m_phase     = PH_IDLE;
        m_done_prev = 1'b0;
        clr_q.delete();
    endtask

    // Next state from the current inputs: reads see old contents, writes apply in priority order.
    task automatic model_step();
        logic start_wr, go, rise;
        int   a;
        for (int i = 0; i < DEPTH; i++) m_nxt[i] = m_mem[i];
        for (int i = 0; i < 6; i++)
            if (re[i / 3]) m_rd[i] = in_range(f_addr[i]) ? m_mem[int'(f_addr[i])] : 32'h0;
        if (cs && rd) m_avl = in_range(32'(a_addr)) ? m_mem[int'(a_addr)] : 32'h0;
        if (cs && wr && in_range(32'(a_addr))) m_nxt[int'(a_addr)] = a_wdata;
        for (int i = 0; i < 6; i++)
            if (we[i / 3] && in_range(f_addr[i])) m_nxt[int'(f_addr[i])] = f_data[i];
        start_wr = cs && wr && (a_addr == 7'd2);
        go       = start_wr && a_wdata[0];
        rise     = fdone && !m_done_prev;
        if (m_phase == PH_IDLE) begin
            if (go) begin m_phase = PH_RUN; m_nxt[3] = 32'h0; end
        end else if (m_phase == PH_RUN) begin
            if (rise) begin m_phase = PH_DONE; m_nxt[3] = 32'h1; m_nxt[2] = 32'h0; end
        end else begin
            if (go) begin m_phase = PH_RUN; m_nxt[3] = 32'h0; end
            else if (start_wr) m_phase = PH_IDLE;
        end
        m_done_prev = fdone;
        if (clr_q.size() > 0) begin
            a = clr_q.pop_front();
            m_nxt[a] = 32'h0;
        end
        if (clr) begin
            clr_q.delete();
            for (int k = 84; k <= 113; k++) clr_q.push_back(k);
        end
        for (int i = 0; i < DEPTH; i++) m_mem[i] = m_nxt[i];
    endtask

    task automatic tick();
        model_step();
        @(posedge CLK);
        #1;
    endtask

    task automatic host_write(input logic [6:0] a, input logic [31:0] d);
        cs = 1; wr = 1; rd = 0; a_addr = a; a_wdata = d;
        tick();
        cs = 0; wr = 0;
    endtask

    task automatic host_read(input logic [6:0] a);
        cs = 1; rd = 1; wr = 0; a_addr = a;
        tick();
        cs = 0; rd = 0;
    endtask

    task automatic compare_all();
        logic [3:0] exp_p;
        exp_p = (m_mem[1][3:0] > 4'd10) ? 4'd10 : m_mem[1][3:0];
        for (int i = 0; i < 6; i++) check($sformatf("rnd_din%0d", i + 1), din[i], m_rd[i]);
        check("rnd_readdata", rdata, m_avl);
        check("rnd_g", g, m_mem[0]);
        check("rnd_planet_num", 32'(pnum), 32'(exp_p));
        check("rnd_fsm_start", 32'(fstart), 32'(m_mem[2][0]));
    endtask

    function automatic logic [31:0] rnd_addr();
        case ($urandom_range(0, 7))
            0:       return $urandom;
            1, 2:    return 32'($urandom_range(80, 90));
            3:       return 32'($urandom_range(0, 3));
            default: return 32'($urandom_range(0, 119));
        endcase
    endfunction

    typedef struct {
        logic        wr;
        logic        rd;
        logic [6:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic [31:0] exp_g;
        logic [3:0]  exp_pnum;
    } host_vec_t;

    host_vec_t vecs [13];

    initial begin
        logic seen;

        vecs[0]  = '{1'b1, 1'b0, 7'd0,   32'h40800000, 32'h00000000, 32'h40800000, 4'd0};
        vecs[1]  = '{1'b1, 1'b0, 7'd1,   32'h00000002, 32'h00000000, 32'h40800000, 4'd2};
        vecs[2]  = '{1'b0, 1'b1, 7'd0,   32'h00000000, 32'h40800000, 32'h40800000, 4'd2};
        vecs[3]  = '{1'b1, 1'b0, 7'd1,   32'h0000000F, 32'h40800000, 32'h40800000, 4'd10};
        vecs[4]  = '{1'b1, 1'b0, 7'd1,   32'h0000000A, 32'h40800000, 32'h40800000, 4'd10};
        vecs[5]  = '{1'b1, 1'b0, 7'd1,   32'h00000009, 32'h40800000, 32'h40800000, 4'd9};
        vecs[6]  = '{1'b0, 1'b1, 7'd1,   32'h00000000, 32'h00000009, 32'h40800000, 4'd9};
        vecs[7]  = '{1'b1, 1'b0, 7'd120, 32'hDEADBEEF, 32'h00000009, 32'h40800000, 4'd9};
        vecs[8]  = '{1'b0, 1'b1, 7'd120, 32'h00000000, 32'h00000000, 32'h40800000, 4'd9};
        vecs[9]  = '{1'b0, 1'b1, 7'd113, 32'h00000000, 32'h00000000, 32'h40800000, 4'd9};
        vecs[10] = '{1'b1, 1'b1, 7'd113, 32'h12345678, 32'h00000000, 32'h40800000, 4'd9};
        vecs[11] = '{1'b0, 1'b1, 7'd113, 32'h00000000, 32'h12345678, 32'h40800000, 4'd9};
        vecs[12] = '{1'b1, 1'b0, 7'd1,   32'hFFFFFFF2, 32'h12345678, 32'h40800000, 4'd2};

        cs = 0; rd = 0; wr = 0; a_addr = '0; a_wdata = '0;
        re = 0; we = 0; fdone = 0; clr = 0;
        for (int i = 0; i < 6; i++) begin f_addr[i] = 32'd200; f_data[i] = '0; end

        // reset state
        RESET_N = 1'b1;
        #1 RESET_N = 1'b0;
        model_reset();
        #2;
        check("reset_g", g, 32'h0);
        check("reset_planet_num", 32'(pnum), 32'h0);
        check("reset_fsm_start", 32'(fstart), 32'h0);
        check("reset_readdata", rdata, 32'h0);
        check("reset_din1", din[0], 32'h0);
        check("reset_din6", din[5], 32'h0);
        @(posedge CLK);
        #1 RESET_N = 1'b1;

        // host table: G / PLANET_NUM decode, out-of-range, read-during-write
        for (int v = 0; v < 13; v++) begin
            cs = 1; wr = vecs[v].wr; rd = vecs[v].rd;
            a_addr = vecs[v].addr; a_wdata = vecs[v].wdata;
            tick();
            check($sformatf("vec%0d_readdata", v), rdata, vecs[v].exp_rdata);
            check($sformatf("vec%0d_g", v), g, vecs[v].exp_g);
            check($sformatf("vec%0d_planet_num", v), 32'(pnum), 32'(vecs[v].exp_pnum));
        end
        cs = 0; wr = 0; rd = 0;

        // FSM read banks, hold behaviour, out-of-range addresses
        host_write(7'd24, 32'h3F800000);
        host_write(7'd25, 32'hBF800000);
        re = 2'd3; f_addr[0] = 32'd24; f_addr[3] = 32'd25;
        tick();
        check("bank_rd_din1", din[0], 32'h3F800000);
        check("bank_rd_din4", din[3], 32'hBF800000);
        check("bank_rd_din2_oor", din[1], 32'h0);
        re = 2'd1; f_addr[0] = 32'd25; f_addr[3] = 32'd24;
        tick();
        check("bank1_din1", din[0], 32'hBF800000);
        check("bank1_din4_hold", din[3], 32'hBF800000);
        f_addr[0] = 32'h00000118;
        tick();
        check("upper_bits_din1", din[0], 32'h0);
        re = 2'd2; f_addr[3] = 32'd114;
        tick();
        check("addr114_din4", din[3], 32'h0);
        re = 2'd1; we = 2'd1; f_addr[0] = 32'd24; f_data[0] = 32'h11111111;
        tick();
        check("fsm_rdw_old", din[0], 32'h3F800000);
        we = 2'd0;
        tick();
        check("fsm_rdw_new", din[0], 32'h11111111);
        re = 2'd0;

        // write priority: port 4 beats port 1 beats host
        we = 2'd3; f_addr[0] = 32'd84; f_addr[3] = 32'd84; f_data[0] = 32'd1; f_data[3] = 32'd2;
        cs = 1; wr = 1; a_addr = 7'd84; a_wdata = 32'd7;
        tick();
        cs = 0; wr = 0; we = 2'd0;
        host_read(7'd84);
        check("prio_mem84", rdata, 32'd2);
        f_addr[0] = 32'd200; f_addr[3] = 32'd200;

        // START / DONE handshake
        host_write(7'd2, 32'd1);
        check("start_set", 32'(fstart), 32'd1);
        host_read(7'd3);
        check("done_cleared", rdata, 32'd0);
        fdone = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 2 && !seen; k++) begin
            tick();
            if (fstart == 1'b0) seen = 1'b1;
        end
        check("start_drop_within_2", 32'(seen), 32'd1);
        host_read(7'd3);
        check("done_flag", rdata, 32'd1);
        host_write(7'd2, 32'd1);
        check("rerun_start", 32'(fstart), 32'd1);
        host_read(7'd3);
        check("rerun_done_cleared", rdata, 32'd0);
        check("level_no_edge", 32'(fstart), 32'd1);
        fdone = 1'b0; tick();
        fdone = 1'b1; tick();
        check("second_done_start", 32'(fstart), 32'd0);
        host_write(7'd2, 32'd0);
        host_write(7'd3, 32'd0);
        fdone = 1'b0; tick();
        fdone = 1'b1; tick();
        host_read(7'd3);
        check("idle_edge_ignored", rdata, 32'd0);
        check("idle_start_low", 32'(fstart), 32'd0);
        fdone = 1'b0;

        // acceleration clear sweep
        for (int a = 84; a <= 113; a++) host_write(7'(a), 32'hFFFFFFFF);
        host_write(7'd83, 32'hA5A5A5A5);
        clr = 1'b1; tick(); clr = 1'b0;
        repeat (29) tick();
        host_read(7'd113);
        check("clear_last_old", rdata, 32'hFFFFFFFF);
        for (int a = 84; a <= 113; a++) begin
            host_read(7'(a));
            check($sformatf("clear_acc%0d", a), rdata, 32'h0);
        end
        host_read(7'd83);
        check("clear_addr83", rdata, 32'hA5A5A5A5);
        host_read(7'd114);
        check("clear_addr114", rdata, 32'h0);

        // reset in the middle of a clear
        for (int a = 84; a <= 113; a++) host_write(7'(a), 32'hFFFFFFFF);
        clr = 1'b1; tick(); clr = 1'b0;
        re = 2'd1; f_addr[0] = 32'd0; cs = 1; rd = 1; a_addr = 7'd0;
        repeat (10) tick();
        check("pre_reset_g", g, 32'h40800000);
        check("pre_reset_din1", din[0], 32'h40800000);
        check("pre_reset_readdata", rdata, 32'h40800000);
        re = 2'd0; cs = 0; rd = 0;
        #2 RESET_N = 1'b0;
        #1;
        model_reset();
        check("midclr_g", g, 32'h0);
        check("midclr_planet_num", 32'(pnum), 32'h0);
        check("midclr_fsm_start", 32'(fstart), 32'h0);
        check("midclr_readdata", rdata, 32'h0);
        check("midclr_din1", din[0], 32'h0);
        @(posedge CLK);
        #1 RESET_N = 1'b1;
        host_read(7'd100);
        check("post_reset_addr100", rdata, 32'h0);
        host_read(7'd113);
        check("post_reset_addr113", rdata, 32'h0);

        // random traffic against the model
        for (int n = 0; n < 2000; n++) begin
            cs      = 1'($urandom_range(0, 1));
            rd      = 1'($urandom_range(0, 1));
            wr      = 1'($urandom_range(0, 1));
            a_addr  = 7'(rnd_addr());
            a_wdata = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
            re      = 2'($urandom_range(0, 3));
            we      = 2'($urandom_range(0, 3));
            for (int i = 0; i < 6; i++) begin
                f_addr[i] = rnd_addr();
                f_data[i] = $urandom;
            end
            if ($urandom_range(0, 7) == 0) fdone = ~fdone;
            clr = ($urandom_range(0, 63) == 0);
            tick();
            compare_all();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/gravsim_regfile.md
GRAVSIM_REGFILE -- requirements
Module: gravsim_regfile

Interface
REQ-001 Parameters: DEPTH, default 114, number of 32-bit words; MAX_PLANETS, default 10, planets stored per field.
REQ-002 CLK  in  1  single clock; all state changes on posedge CLK.
REQ-003 RESET_N  in  1  reset, asynchronous, active-low.
REQ-004 AVL_CS, AVL_READ, AVL_WRITE  in  1 each  host chip-select, read strobe and write strobe.
REQ-005 AVL_ADDR  in  7  host word address.
REQ-006 AVL_WRITEDATA  in  32  host write data.
REQ-007 AVL_READDATA  out  32  host read data.
REQ-008 FSM_re, FSM_we  in  2 each  FSM bank enables: 1 = ports 1-3, 2 = ports 4-6, 3 = all six, 0 = none.
REQ-009 ADDR1..ADDR6  in  32 each  FSM word addresses.
REQ-010 DATA1..DATA6  in  32 each  FSM write data.
REQ-011 DATA1in..DATA6in  out  32 each  FSM read data.
REQ-012 FSM_DONE  in  1  FSM completion level.
REQ-013 clear_accs  in  1  one-cycle pulse requesting an acceleration clear.
REQ-014 FSM_START  out  1  run request to the FSM.
REQ-015 G  out  32  gravitational constant, float.
REQ-016 PLANET_NUM  out  4  active planet count.

Function
REQ-017 Word map: G 0, NUM 1, START 2, DONE 3; planet p (1..10) at MASS 3+p, RAD 13+p, POS_X/Y/Z 23+p/33+p/43+p, VEL_X/Y/Z 53+p/63+p/73+p, ACC_X/Y/Z 83+p/93+p/103+p.
REQ-018 FSM read: with FSM_re bit0 set, DATA1in..3in are loaded with mem[ADDR1..3] on the next posedge; bit1 does the same for ports 4-6; read latency is 1 cycle.
REQ-019 Any DATAxin whose bank is not enabled holds its previous value.
REQ-020 FSM write: with FSM_we bit0 set, mem[ADDR1..3] <= DATA1..3; bit1 does the same for ports 4-6.
REQ-021 Same-cycle FSM writes to one address: the highest-numbered port wins.
REQ-022 Host: AVL_CS&AVL_WRITE writes mem[AVL_ADDR]; AVL_CS&AVL_READ loads AVL_READDATA next posedge (1-cycle latency); otherwise AVL_READDATA holds.
REQ-023 Host write and FSM write to the same address in the same cycle: the FSM write wins.
REQ-024 Read during write to the same address, on either port: returns the old data (no bypass).
REQ-025 Any address >= DEPTH (upper ADDRx bits nonzero included) reads 0; writes to it are ignored.
REQ-026 Outputs: G = mem[0]; PLANET_NUM = mem[1][3:0] saturated to MAX_PLANETS; FSM_START = mem[2][0].
REQ-027 START/DONE control FSM, states IDLE, RUN, DONE.
  - IDLE -> RUN on host write of START with bit0 = 1; this also clears mem[3].
  - RUN -> DONE on FSM_DONE rising edge (registered edge detect): mem[3] <= 1, mem[2] <= 0.
  - DONE -> RUN on the next host START=1 write; DONE -> IDLE on a host START=0 write.
  - FSM_DONE edges while in IDLE are ignored.
REQ-028 clear_accs starts a sequencer that zeroes ACC words 84..113 one per cycle (30 cycles, counter wraps to idle).
  - FSM writes to ACC words during the clear are overridden by the clear only at the word currently being cleared.
  - clear_accs asserted while a clear is busy restarts the counter at 84.

Reset
REQ-029 On RESET_N low, asynchronously: all mem words, DATA1in..6in, AVL_READDATA, the edge-detect flop and the clear counter go to 0; control state goes to IDLE; hence FSM_START=0, G=0, PLANET_NUM=0.
REQ-030 Reset mid-clear or mid-RUN aborts the operation; the block is idle on release, with no pending writes.

Verification
REQ-031 Host writes mem[0]=40800000h, mem[1]=2 -> G=40800000h, PLANET_NUM=2 next cycle; write mem[1]=15 -> PLANET_NUM=10.
REQ-032 Preload POS_X1=3F800000h (addr 24), POS_X2=BF800000h (addr 25); FSM_re=3, ADDR1=24, ADDR4=25 -> next cycle DATA1in=3F800000h, DATA4in=BF800000h; then FSM_re=1 -> DATA4in holds.
REQ-033 FSM_we=3, ADDR1=ADDR4=84, DATA1=1, DATA4=2, host write 84<=7 same cycle -> mem[84]=2.
REQ-034 Host START=1 -> FSM_START=1; FSM_DONE 0->1 -> mem[3]=1 and FSM_START=0 within 2 cycles; host read addr 3 returns 1 after 1 cycle.
REQ-035 Fill 84..113 with FFFFFFFFh, pulse clear_accs -> after 30 cycles all ACC words read 0, addr 83 and addr 114 untouched/0.
REQ-036 Assert RESET_N low mid-clear at cycle 10 -> all outputs 0 immediately; after release a read of addr 100 returns 0.
